// File: rtl/debnc_pkg.sv
// Shared types and sizing helpers for the multi-channel switch debouncer.
package debnc_pkg;

  typedef enum logic [1:0] {LO, W_HI, HI, W_LO} debnc_state_t;

  // Stable-counter width: enough bits to hold 0..n.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debnc_ch.sv
// One debounce channel: 2-flop synchroniser, 4-state wait FSM, stable counter
// and registered rise/fall pulses aligned with the first cycle of the new level.
module debnc_ch
  import debnc_pkg::*;
#(
  parameter int N_STABLE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic s_in,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(N_STABLE);

  logic            s_meta, s_sync;
  debnc_state_t    st, st_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            last, db_nx;

  assign last = (cnt == CW'(N_STABLE - 1));

  // A reversal in a wait state wins over a coincident tick.
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    case (st)
      LO:   if (s_sync) begin st_nx = W_HI; cnt_nx = '0; end
      W_HI: begin
        if (!s_sync)   st_nx = LO;
        else if (tick) begin
          if (last) st_nx = HI;
          else      cnt_nx = cnt + 1'b1;
        end
      end
      HI:   if (!s_sync) begin st_nx = W_LO; cnt_nx = '0; end
      W_LO: begin
        if (s_sync)    st_nx = HI;
        else if (tick) begin
          if (last) st_nx = LO;
          else      cnt_nx = cnt + 1'b1;
        end
      end
      default: st_nx = LO;
    endcase
  end

  assign db    = (st == HI) || (st == W_LO);
  assign db_nx = (st_nx == HI) || (st_nx == W_LO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      st     <= LO;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s_meta <= s_in;
      s_sync <= s_meta;
      st     <= st_nx;
      cnt    <= cnt_nx;
      rise   <= db_nx & ~db;
      fall   <= ~db_nx & db;
    end
  end

endmodule

// File: rtl/debnc_multi.sv
// N-channel switch debouncer: one shared sample-tick divider feeding an array
// of independent per-channel debouncers with per-bit input polarity.
module debnc_multi
  import debnc_pkg::*;
#(
  parameter int              N_CH       = 4,
  parameter int              TICK_DIV   = 1000000,
  parameter int              N_STABLE   = 3,
  parameter logic [N_CH-1:0] ACTIVE_LOW = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            tick
);

  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0] tcnt;

  // tick is registered one count early so it is high exactly while tcnt==TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      tcnt <= (tcnt == TW'(TICK_DIV - 1)) ? '0 : tcnt + 1'b1;
      tick <= (tcnt == TW'(TICK_DIV - 2));
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debnc_ch #(.N_STABLE(N_STABLE)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .s_in  (sw[i] ^ ACTIVE_LOW[i]),
      .db    (db[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_debnc_multi.sv
// Bench for debnc_multi: directed scenarios plus random switching, checked
// every cycle against a tick-counting behavioural model.
module tb_debnc_multi;

  localparam int         NC = 2;
  localparam int         TD = 4;
  localparam int         NS = 3;
  localparam logic [1:0] AL = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] sw = '0;
  logic [NC-1:0] db, rise, fall;
  logic          tick;

  debnc_multi #(.N_CH(NC), .TICK_DIV(TD), .N_STABLE(NS), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .db(db), .rise(rise), .fall(fall), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // Model: synced level must differ from db and survive NS ticks without reverting.
  logic [NC-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_rise = '0, m_fall = '0, m_pend = '0;
  int            m_nt [NC];
  int            m_tc = 0;
  logic          m_tick = 1'b0;

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_pend = '0;
      m_tc = 0; m_tick = 1'b0;
      for (int c = 0; c < NC; c++) m_nt[c] = 0;
    end else begin
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < NC; c++) begin
        if (!m_pend[c]) begin
          if (m_s2[c] !== m_db[c]) begin m_pend[c] = 1'b1; m_nt[c] = 0; end
        end else if (m_s2[c] === m_db[c]) begin
          m_pend[c] = 1'b0;
        end else if (m_tick) begin
          m_nt[c]++;
          if (m_nt[c] == NS) begin
            m_db[c]   = m_s2[c];
            m_pend[c] = 1'b0;
            m_rise[c] = m_s2[c];
            m_fall[c] = !m_s2[c];
          end
        end
      end
      m_s2   = m_s1;
      m_s1   = sw ^ AL;
      m_tc   = (m_tc + 1) % TD;
      m_tick = (m_tc == TD - 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    sw = 2'b11; rst_n = 1'b0;
    repeat (3) begin
      cyc();
      checks++;
      if ({db, rise, fall, tick} !== 7'b0) begin
        errs++;
        $display("FAIL reset_state got db=%b rise=%b fall=%b tick=%b want all 0", db, rise, fall, tick);
      end
    end
    rst_n = 1'b1;
    // counter reads 0 in the release cycle, so count==3 lands after the 3rd edge
    for (int k = 1; k <= 8; k++) begin
      cyc();
      checks++;
      if (tick !== (k == 3 || k == 7)) begin
        errs++;
        $display("FAIL tick_phase k=%0d got tick=%b want %b", k, tick, (k == 3 || k == 7));
      end
      checks++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        errs++;
        $display("FAIL reset_model got db=%b r=%b f=%b tk=%b want db=%b r=%b f=%b tk=%b",
                 db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
    end
  endtask

  task automatic test_polarity();
    int t1 = -1, rc = 0, fc = 0;
    sw = 2'b00; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (rise[1] === 1'b1) rc++;
      if (db[1] === 1'b1 && t1 < 0) t1 = k;
      checks++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        errs++;
        $display("FAIL pol_model got db=%b r=%b f=%b tk=%b want db=%b r=%b f=%b tk=%b",
                 db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
    end
    checks++;
    if (t1 < 1 || t1 > 15 || rc != 1) begin
      errs++;
      $display("FAIL pol_rise got latency=%0d rises=%0d want 1..15 and 1", t1, rc);
    end
    sw[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (fall[1] === 1'b1) fc++;
      checks++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        errs++;
        $display("FAIL pol_model2 got db=%b r=%b f=%b tk=%b want db=%b r=%b f=%b tk=%b",
                 db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
    end
    checks++;
    if (db[1] !== 1'b0 || fc != 1) begin
      errs++;
      $display("FAIL pol_fall got db1=%b falls=%0d want 0 and 1", db[1], fc);
    end
  endtask

  task automatic test_press();
    int t0 = -1, rc = 0;
    logic rise_at_first = 1'b0;
    sw[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (rise[0] === 1'b1) rc++;
      if (db[0] === 1'b1 && t0 < 0) begin t0 = k; rise_at_first = rise[0]; end
      checks++;
      if (db[1] !== 1'b0) begin
        errs++;
        $display("FAIL press_other got db1=%b want 0", db[1]);
      end
      checks++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        errs++;
        $display("FAIL press_model got db=%b r=%b f=%b tk=%b want db=%b r=%b f=%b tk=%b",
                 db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
    end
    checks++;
    if (t0 < 11 || t0 > 15 || rc != 1 || rise_at_first !== 1'b1) begin
      errs++;
      $display("FAIL press_latency got latency=%0d rises=%0d rise_at_first=%b want 11..15,1,1",
               t0, rc, rise_at_first);
    end
  endtask

  task automatic test_release();
    int t0 = -1, fc = 0;
    sw[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (fall[0] === 1'b1) fc++;
      if (db[0] === 1'b0 && t0 < 0) t0 = k;
      checks++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        errs++;
        $display("FAIL rel_model got db=%b r=%b f=%b tk=%b want db=%b r=%b f=%b tk=%b",
                 db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
    end
    checks++;
    if (t0 < 11 || t0 > 15 || fc != 1) begin
      errs++;
      $display("FAIL rel_latency got latency=%0d falls=%0d want 11..15 and 1", t0, fc);
    end
    sw[0] = 1'b1;
    repeat (20) cyc();
    // glitch partway through the release wait must restart it
    sw[0] = 1'b0;
    repeat (4) cyc();
    sw[0] = 1'b1;
    cyc();
    sw[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      checks++;
      if (db[0] !== 1'b1 || fall[0] !== 1'b0) begin
        errs++;
        $display("FAIL glitch_hold k=%0d got db0=%b fall0=%b want 1 and 0", k, db[0], fall[0]);
      end
    end
    for (int k = 1; k <= 14; k++) begin
      cyc();
      checks++;
      if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick}) begin
        errs++;
        $display("FAIL glitch_model got db=%b r=%b f=%b tk=%b want db=%b r=%b f=%b tk=%b",
                 db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
      end
    end
    checks++;
    if (db[0] !== 1'b0) begin
      errs++;
      $display("FAIL glitch_final got db0=%b want 0", db[0]);
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 60; k++) begin
      sw[0] = (k < 40) ? ~k[1] : 1'b0;
      cyc();
      checks++;
      if (db[0] !== 1'b0 || rise[0] !== 1'b0 || fall[0] !== 1'b0) begin
        errs++;
        $display("FAIL bounce k=%0d got db0=%b rise0=%b fall0=%b want 0", k, db[0], rise[0], fall[0]);
      end
    end
  endtask

  task automatic test_concurrent();
    int t0 = -1, t1 = -1;
    logic [1:0] r_at = '0;
    sw = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (db[0] === 1'b1 && t0 < 0) begin t0 = k; r_at = rise; end
      if (db[1] === 1'b1 && t1 < 0) t1 = k;
    end
    checks++;
    if (t0 < 0 || t0 != t1 || r_at !== 2'b11) begin
      errs++;
      $display("FAIL concurrent got t0=%0d t1=%0d rise=%b want equal and 11", t0, t1, r_at);
    end
    sw = 2'b10;
    repeat (6) cyc();
    rst_n = 1'b0;
    cyc();
    checks++;
    if (db !== 2'b00 || rise !== 2'b00 || fall !== 2'b00) begin
      errs++;
      $display("FAIL reset_midwait got db=%b rise=%b fall=%b want 00", db, rise, fall);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int cyc_left = 800;
    while (cyc_left > 0) begin
      sw = NC'($urandom);
      for (int h = $urandom_range(1, 16); h > 0 && cyc_left > 0; h--) begin
        cyc();
        cyc_left--;
        checks++;
        if ({db, rise, fall, tick} !== {m_db, m_rise, m_fall, m_tick} || (rise & fall) !== 2'b00) begin
          errs++;
          $display("FAIL random got db=%b r=%b f=%b tk=%b want db=%b r=%b f=%b tk=%b",
                   db, rise, fall, tick, m_db, m_rise, m_fall, m_tick);
        end
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) m_nt[c] = 0;
    test_reset();
    test_polarity();
    test_press();
    test_release();
    test_bounce();
    test_concurrent();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
